// File: rtl/int_to_bf16.sv
// int_to_bf16: two-stage signed integer to bfloat16 converter (RNE) with valid/ready flow control
module lzc #(
  parameter int W = 16
) (
  input  logic [W-1:0]             a,
  output logic [$clog2(W+1)-1:0]   cnt
);
  localparam int lw = $clog2(W + 1);
  // Highest set bit wins; an all-zero input reports W
  always_comb begin
    cnt = lw'(W);
    for (int i = 0; i < W; i++) cnt = a[i] ? lw'(W - 1 - i) : cnt;
  end
endmodule

module int_to_bf16 #(
  parameter int IN_W = 16
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            valid_i,
  input  logic [IN_W-1:0] data_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [15:0]     data_o,
  input  logic            ready_i
);
  localparam int lw = $clog2(IN_W + 1);
  localparam logic [IN_W-2:0] sticky_mask = (IN_W-1)'((64'd1 << (IN_W - 9)) - 64'd1);
  logic            v1, v2, sgn1, z1, in_xfer, ld2, guard, sticky, rnd;
  logic [IN_W-1:0] mag1;
  logic [IN_W-2:0] norm;
  logic [lw-1:0]   lz;
  logic [6:0]      man;
  logic [7:0]      man8, exp;
  logic [15:0]     res;
  assign ready_o = nreset & (!v1 | !v2 | ready_i);
  assign valid_o = v2;
  assign in_xfer = valid_i & ready_o;
  assign ld2     = v1 & (!v2 | ready_i);
  lzc #(.W(IN_W)) u_lzc (.a(mag1), .cnt(lz));
  // Normalize, round to nearest even, and pack; the leading one is implicit so it is dropped
  always_comb begin
    norm   = (IN_W-1)'(mag1 << lz);
    man    = norm[IN_W-2 -: 7];
    guard  = norm[IN_W-9];
    sticky = |(norm & sticky_mask);
    rnd    = guard & (sticky | man[0]);
    man8   = {1'b0, man} + 8'(rnd);
    exp    = 8'(126 + IN_W) - 8'(lz) + 8'(man8[7]);
    res    = z1 ? 16'h0000 : {sgn1, exp, man8[6:0]};
  end
  // Stage-1 payload: sign, magnitude (most negative input maps to 2^(IN_W-1)) and zero flag
  always_ff @(posedge clk)
    if (in_xfer) begin
      sgn1 <= data_i[IN_W-1];
      mag1 <= data_i[IN_W-1] ? -data_i : data_i;
      z1   <= data_i == '0;
    end
  // Pipeline occupancy and registered result; reset discards anything in flight
  always_ff @(posedge clk)
    if (!nreset) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      data_o <= 16'h0000;
    end else begin
      v1 <= in_xfer ? 1'b1 : (ld2 ? 1'b0 : v1);
      v2 <= ld2 ? 1'b1 : (ready_i ? 1'b0 : v2);
      if (ld2) data_o <= res;
    end
endmodule

// File: tb/tb_int_to_bf16.sv
// tb_int_to_bf16: directed and random checks of int_to_bf16 against a real-arithmetic reference
module tb_int_to_bf16;
  localparam int IN_W = 16;
  logic            clk = 1'b0, nreset = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [IN_W-1:0] data_i = '0;
  logic            ready_o, valid_o;
  logic [15:0]     data_o;
  int tests = 0, fails = 0, acc = 0, outs = 0;
  logic [15:0] sb[$];
  logic        hold = 1'b0;
  logic [15:0] held = 16'h0;

  int_to_bf16 #(.IN_W(IN_W)) dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [IN_W-1:0] d);
    logic [63:0] b;
    logic [7:0]  m8;
    int          e2;
    if (d == '0) return 16'h0000;
    b  = $realtobits(real'(int'($signed(d))));
    m8 = {1'b0, b[51:45]} + 8'(b[44] & ((|b[43:0]) | b[45]));
    e2 = int'(b[62:52]) - 1023 + 127 + int'(m8[7]);
    return {b[63], e2[7:0], m8[6:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!nreset) begin
      sb.delete();
      hold <= 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 16'(valid_o), 16'd1);
        check("hold_data", data_o, held);
      end
      if (valid_o && ready_i) begin
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL spurious_output observed=%h expected=none", data_o);
        end
        if (sb.size() != 0) check("stream", data_o, sb.pop_front());
        outs++;
      end
      if (valid_i && ready_o) begin
        sb.push_back(model(data_i));
        acc++;
      end
      hold <= valid_o && !ready_i;
      held <= data_o;
    end
  end

  initial begin
    logic [IN_W-1:0] vals [6] = '{16'd257, 16'd259, 16'd32767, 16'h8000, 16'd16384, 16'hFFFD};
    logic [15:0]     exps [6] = '{16'h4380, 16'h4382, 16'h4700, 16'hC700, 16'h4680, 16'hC040};
    int n;
    ready_i = 1'b1;
    repeat (2) tick();
    check("rst_ready", 16'(ready_o), 16'd0);
    check("rst_valid", 16'(valid_o), 16'd0);
    check("rst_data", data_o, 16'h0000);
    nreset = 1'b1;
    valid_i = 1'b1; data_i = 16'd0;
    tick();
    check("lat_not_yet", 16'(valid_o), 16'd0);
    data_i = 16'd1;
    tick();
    check("lat_valid", 16'(valid_o), 16'd1);
    check("zero", data_o, 16'h0000);
    data_i = 16'hFFFF;
    tick();
    check("one", data_o, 16'h3F80);
    valid_i = 1'b0;
    tick();
    check("minus_one", data_o, 16'hBF80);
    tick();
    check("idle_valid", 16'(valid_o), 16'd0);
    for (int i = 0; i < 7; i++) begin
      valid_i = i < 6;
      if (i < 6) data_i = vals[i];
      tick();
      if (i >= 1) check("round_ext", data_o, exps[i-1]);
    end
    valid_i = 1'b0;
    tick();
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 16'd1;
    tick();
    check("bp_ready_first", 16'(ready_o), 16'd1);
    data_i = 16'd2;
    tick();
    check("bp_ready_full", 16'(ready_o), 16'd0);
    data_i = 16'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready_low", 16'(ready_o), 16'd0);
      check("bp_hold", data_o, 16'h3F80);
    end
    ready_i = 1'b1;
    #1;
    check("bp_ready_comb", 16'(ready_o), 16'd1);
    tick();
    check("bp_out2", data_o, 16'h4000);
    valid_i = 1'b0;
    tick();
    check("bp_out3", data_o, 16'h4040);
    check("bp_out3_valid", 16'(valid_o), 16'd1);
    tick();
    check("bp_drained", 16'(valid_o), 16'd0);
    for (int i = 0; i < 400; i++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 3) != 0);
      data_i  = (i % 17 == 0) ? 16'h8000 : IN_W'($urandom);
      tick();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_empty", 16'(sb.size()), 16'd0);
    check("count_match", 16'(outs), 16'(acc));
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 16'd100;
    tick();
    data_i = 16'd200;
    tick();
    check("rst_inflight", 16'(valid_o), 16'd1);
    valid_i = 1'b0;
    nreset = 1'b0;
    tick();
    check("midrst_valid", 16'(valid_o), 16'd0);
    check("midrst_data", data_o, 16'h0000);
    nreset = 1'b1; ready_i = 1'b1;
    valid_i = 1'b1; data_i = 16'd2;
    tick();
    valid_i = 1'b0;
    tick();
    check("post_rst_valid", 16'(valid_o), 16'd1);
    check("post_rst_data", data_o, 16'h4000);
    tick();
    check("post_rst_idle", 16'(valid_o), 16'd0);
    check("post_rst_sb", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
